// File: rtl/dual_issue_fetch.sv
// dual_issue_fetch: two-wide instruction fetch stage.
// Fetches an aligned-by-address pair {PC, PC+1} per request. Slot 0 always
// holds the even-address instruction and slot 1 the odd one; 'first' tells
// decode which slot is older. A one-entry pair buffer absorbs a response that
// arrives while decode is stalled. Branches may land while a request is still
// outstanding; that response is dropped in the DROP state.
// Optional feature: define FETCH_PERF_COUNT_EN to add the 32-bit saturating
// fetch_bubble_count output.
// Pipeline mask and NOP opcode macros below are defaults for standalone
// builds; a core that already defines them keeps its own values.

`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 5'b00001
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 5'b00010
`endif
`ifndef PIPE_REG_ID_EX
`define PIPE_REG_ID_EX 5'b00100
`endif
`ifndef PIPE_REG_EX_MEM
`define PIPE_REG_EX_MEM 5'b01000
`endif
`ifndef PIPE_REG_MEM_WB
`define PIPE_REG_MEM_WB 5'b10000
`endif
`ifndef OP_CODE_NOP
`define OP_CODE_NOP 6'b111111
`endif

module dual_issue_fetch #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [`NUM_PIPE_MASKS-1:0] stall0,
   input  logic [`NUM_PIPE_MASKS-1:0] stall1,
   input  logic [`NUM_PIPE_MASKS-1:0] nop0,
   input  logic [`NUM_PIPE_MASKS-1:0] nop1,
   input  logic                       branch_taken,
   input  logic [ADDR_WIDTH-1:0]      branch_address,
   output logic                       imem_req,
   output logic [ADDR_WIDTH-1:0]      imem_addr,
   input  logic                       imem_ready,
   input  logic [INST_WIDTH-1:0]      imem_data_even,
   input  logic [INST_WIDTH-1:0]      imem_data_odd,
   output logic [INST_WIDTH-1:0]      if_id_instruction0,
   output logic [INST_WIDTH-1:0]      if_id_instruction1,
   output logic [ADDR_WIDTH-1:0]      if_id_pc0,
   output logic [ADDR_WIDTH-1:0]      if_id_pc1,
   output logic                       if_id_valid0,
   output logic                       if_id_valid1,
   output logic                       first
`ifdef FETCH_PERF_COUNT_EN
   ,
   output logic [31:0]                fetch_bubble_count
`endif
);

   localparam logic [INST_WIDTH-1:0] NOP_WORD = {`OP_CODE_NOP, {(INST_WIDTH-6){1'b0}}};

   typedef enum logic [1:0] {S_FETCH, S_BUFFERED, S_DROP} state_t;

   // A fetched pair: start PC of the request plus both instructions.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] start;
      logic [INST_WIDTH-1:0] even;
      logic [INST_WIDTH-1:0] odd;
   } pair_t;

   state_t                           state_q, state_d;
   logic [ADDR_WIDTH-1:0]            pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]            tgt_q, tgt_d;
   pair_t                            buf_q, buf_d;
   logic [1:0][INST_WIDTH-1:0]       inst_q, inst_d;
   logic [1:0][ADDR_WIDTH-1:0]       spc_q, spc_d;
   logic [1:0]                       vld_q, vld_d;
   logic                             first_q, first_d;

   logic                             advance;
   logic [1:0]                       kill, hold, ld;
   logic                             fetch_load, buf_load, capture, pair_avail;
   pair_t                            fetch_pair, pair_sel;
   logic [1:0][INST_WIDTH-1:0]       pair_inst;
   logic [1:0][ADDR_WIDTH-1:0]       pair_pc;

   // Decode controls: the PC only moves when neither slot freezes it.
   assign advance = ~|(stall0 & `PIPE_REG_PC) & ~|(stall1 & `PIPE_REG_PC);
   assign kill    = {|(nop1 & `PIPE_REG_IF_ID),   |(nop0 & `PIPE_REG_IF_ID)};
   assign hold    = {|(stall1 & `PIPE_REG_IF_ID), |(stall0 & `PIPE_REG_IF_ID)};

   // Where a new pair comes from this cycle (memory or buffer), if anywhere.
   assign fetch_load = (state_q == S_FETCH) & imem_ready & ~branch_taken & advance;
   assign capture    = (state_q == S_FETCH) & imem_ready & ~branch_taken & ~advance;
   assign buf_load   = (state_q == S_BUFFERED) & ~branch_taken & advance;
   assign pair_avail = fetch_load | buf_load;

   assign fetch_pair = {pc_q, imem_data_even, imem_data_odd};
   assign pair_sel   = buf_load ? buf_q : fetch_pair;

   // Steer by address parity: for an odd start the even word is start+1.
   always_comb begin
      pair_inst[0] = pair_sel.even;
      pair_inst[1] = pair_sel.odd;
      if (pair_sel.start[0]) begin
         pair_pc[0] = pair_sel.start + ADDR_WIDTH'(1);
         pair_pc[1] = pair_sel.start;
      end else begin
         pair_pc[0] = pair_sel.start;
         pair_pc[1] = pair_sel.start + ADDR_WIDTH'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // FSM next state; a branch always wins over stall/advance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (branch_taken)                  state_d = imem_ready ? S_FETCH : S_DROP;
            else if (imem_ready && !advance)   state_d = S_BUFFERED;
         end
         S_BUFFERED: begin
            if (branch_taken || advance)       state_d = S_FETCH;
         end
         S_DROP: begin
            if (imem_ready)                    state_d = S_FETCH;
         end
         default:                              state_d = S_FETCH;
      endcase
   end

   // FSM outputs: no request while the buffer is full or reset is held.
   always_comb begin
      imem_req  = reset & (state_q != S_BUFFERED);
      imem_addr = pc_q;
   end

   // PC, saved branch target and pair buffer next-state.
   always_comb begin
      pc_d  = pc_q;
      tgt_d = tgt_q;
      buf_d = buf_q;
      case (state_q)
         S_FETCH: begin
            if (branch_taken) begin
               if (imem_ready) pc_d  = branch_address;
               else            tgt_d = branch_address;
            end else if (imem_ready) begin
               // Pair consumed either by IF/ID or by the buffer.
               pc_d = pc_q + ADDR_WIDTH'(2);
               if (capture) buf_d = fetch_pair;
            end
         end
         S_BUFFERED: begin
            if (branch_taken) pc_d = branch_address;
         end
         S_DROP: begin
            if (branch_taken) tgt_d = branch_address;
            if (imem_ready)   pc_d  = branch_taken ? branch_address : tgt_q;
         end
         default: ;
      endcase
   end

   // IF/ID slot next-state: bubble, hold, load or go empty, per slot.
   // A pair offered while a slot holds is still consumed; the hazard unit
   // keeps the PC frozen whenever IF/ID is frozen so nothing is lost.
   always_comb begin
      inst_d  = inst_q;
      spc_d   = spc_q;
      vld_d   = vld_q;
      first_d = first_q;
      ld      = '0;
      if (branch_taken) begin
         vld_d = '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (kill[k]) begin
               vld_d[k] = 1'b0;
            end else if (hold[k]) begin
               vld_d[k] = vld_q[k];
            end else if (pair_avail) begin
               vld_d[k]  = 1'b1;
               inst_d[k] = pair_inst[k];
               spc_d[k]  = pair_pc[k];
               ld[k]     = 1'b1;
            end else begin
               vld_d[k] = 1'b0;
            end
         end
         if (|ld) first_d = pair_sel.start[0];
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         buf_q   <= '0;
         inst_q  <= {2{NOP_WORD}};
         spc_q   <= '0;
         vld_q   <= '0;
         first_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         buf_q   <= buf_d;
         inst_q  <= inst_d;
         spc_q   <= spc_d;
         vld_q   <= vld_d;
         first_q <= first_d;
      end
   end

   // Invalid slots always present a clean NOP to decode.
   always_comb begin
      if_id_instruction0 = vld_q[0] ? inst_q[0] : NOP_WORD;
      if_id_instruction1 = vld_q[1] ? inst_q[1] : NOP_WORD;
      if_id_pc0          = spc_q[0];
      if_id_pc1          = spc_q[1];
      if_id_valid0       = vld_q[0];
      if_id_valid1       = vld_q[1];
      first              = first_q;
   end

`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] bubble_q;

   // Count cycles where IF/ID goes fully empty for reasons other than a branch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                              bubble_q <= '0;
      else if (!branch_taken && vld_d == 2'b00 && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
   end

   assign fetch_bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_dual_issue_fetch.sv
// Bench for dual_issue_fetch: directed phases plus a pair scoreboard.
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 5'b00001
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 5'b00010
`endif
`ifndef PIPE_REG_ID_EX
`define PIPE_REG_ID_EX 5'b00100
`endif
`ifndef OP_CODE_NOP
`define OP_CODE_NOP 6'b111111
`endif

module tb_dual_issue_fetch;
   localparam int AW = 16;
   localparam int IW = 32;
   localparam logic [IW-1:0] NOP_W = {`OP_CODE_NOP, 26'h0};
   localparam logic [`NUM_PIPE_MASKS-1:0] M_PC_IFID = `PIPE_REG_PC | `PIPE_REG_IF_ID;

   logic                       clk = 1'b0;
   logic                       reset = 1'b0;
   logic [`NUM_PIPE_MASKS-1:0] stall0 = '0, stall1 = '0, nop0 = '0, nop1 = '0;
   logic                       branch_taken = 1'b0;
   logic [AW-1:0]              branch_address = '0;
   logic                       imem_req;
   logic [AW-1:0]              imem_addr;
   logic                       imem_ready = 1'b0;
   logic [IW-1:0]              imem_data_even, imem_data_odd;
   logic [IW-1:0]              if_id_instruction0, if_id_instruction1;
   logic [AW-1:0]              if_id_pc0, if_id_pc1;
   logic                       if_id_valid0, if_id_valid1, first;
`ifdef FETCH_PERF_COUNT_EN
   logic [31:0]                fetch_bubble_count;
`endif

   dual_issue_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset),
      .stall0(stall0), .stall1(stall1), .nop0(nop0), .nop1(nop1),
      .branch_taken(branch_taken), .branch_address(branch_address),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_data_even(imem_data_even), .imem_data_odd(imem_data_odd),
      .if_id_instruction0(if_id_instruction0), .if_id_instruction1(if_id_instruction1),
      .if_id_pc0(if_id_pc0), .if_id_pc1(if_id_pc1),
      .if_id_valid0(if_id_valid0), .if_id_valid1(if_id_valid1), .first(first)
`ifdef FETCH_PERF_COUNT_EN
      , .fetch_bubble_count(fetch_bubble_count)
`endif
   );

   always #5 clk = ~clk;

   // Memory image: every word encodes its own address.
   function automatic logic [IW-1:0] inst(input logic [AW-1:0] a);
      return {6'h02, 10'h155, a};
   endfunction

   logic [AW-1:0] ev_a, od_a;
   assign ev_a = imem_addr[0] ? imem_addr + 16'd1 : imem_addr;
   assign od_a = imem_addr[0] ? imem_addr : imem_addr + 16'd1;
   assign imem_data_even = inst(ev_a);
   assign imem_data_odd  = inst(od_a);

   typedef struct {
      logic [AW-1:0] pc0;
      logic [AW-1:0] pc1;
      logic          fst;
   } exp_t;
   exp_t sb_q[$];
   bit   sb_on = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [AW-1:0] p0, input logic [AW-1:0] p1, input logic f);
      exp_t e;
      e.pc0 = p0; e.pc1 = p1; e.fst = f;
      sb_q.push_back(e);
   endtask

   // One clock; outputs sampled 1 time unit after the edge.
   task automatic cyc();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_on && (if_id_valid0 || if_id_valid1)) begin
         if (sb_q.size() == 0) chk("sb_extra", 64'd1, 64'd0);
         else begin
            e = sb_q.pop_front();
            chk("sb_v0",    {63'd0, if_id_valid0}, 64'd1);
            chk("sb_v1",    {63'd0, if_id_valid1}, 64'd1);
            chk("sb_pc0",   {48'd0, if_id_pc0}, {48'd0, e.pc0});
            chk("sb_pc1",   {48'd0, if_id_pc1}, {48'd0, e.pc1});
            chk("sb_i0",    {32'd0, if_id_instruction0}, {32'd0, inst(e.pc0)});
            chk("sb_i1",    {32'd0, if_id_instruction1}, {32'd0, inst(e.pc1)});
            chk("sb_first", {63'd0, first}, {63'd0, e.fst});
         end
      end
   endtask

   initial begin
      // Reset held with a response pending: must be ignored.
      imem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",   {63'd0, imem_req}, 64'd0);
      chk("rst_v0",    {63'd0, if_id_valid0}, 64'd0);
      chk("rst_v1",    {63'd0, if_id_valid1}, 64'd0);
      chk("rst_i0",    {32'd0, if_id_instruction0}, {32'd0, NOP_W});
      chk("rst_i1",    {32'd0, if_id_instruction1}, {32'd0, NOP_W});
      chk("rst_first", {63'd0, first}, 64'd0);
      reset = 1'b1;
      #1;
      chk("rel_req",  {63'd0, imem_req}, 64'd1);
      chk("rel_addr", {48'd0, imem_addr}, 64'd0);

      // Free-running stream.
      push(16'd0, 16'd1, 1'b0); push(16'd2, 16'd3, 1'b0); push(16'd4, 16'd5, 1'b0);
      sb_on = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("b_addr", {48'd0, imem_addr}, 64'(2 * (i + 1)));
      end
      sb_on = 1'b0;
      chk("b_sb_empty", 64'(sb_q.size()), 64'd0);

      // Full stall: one pair parks in the buffer, IF/ID holds 4/5.
      stall0 = M_PC_IFID; stall1 = M_PC_IFID;
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("c_req",  {63'd0, imem_req}, 64'd0);
         chk("c_addr", {48'd0, imem_addr}, 64'h8);
         chk("c_pc0",  {48'd0, if_id_pc0}, 64'h4);
         chk("c_pc1",  {48'd0, if_id_pc1}, 64'h5);
         chk("c_v0",   {63'd0, if_id_valid0}, 64'd1);
      end
      stall0 = '0; stall1 = '0;
      push(16'd6, 16'd7, 1'b0); push(16'd8, 16'd9, 1'b0);
      sb_on = 1'b1;
      cyc();
      chk("c_req_rel", {63'd0, imem_req}, 64'd1);
      cyc();
      sb_on = 1'b0;

      // Split stall: slot 0 bubbled, slot 1 held, PC frozen.
      imem_ready = 1'b0;
      nop0 = `PIPE_REG_IF_ID; stall1 = M_PC_IFID | `PIPE_REG_ID_EX;
      cyc();
      chk("d_v0",   {63'd0, if_id_valid0}, 64'd0);
      chk("d_i0",   {32'd0, if_id_instruction0}, {32'd0, NOP_W});
      chk("d_v1",   {63'd0, if_id_valid1}, 64'd1);
      chk("d_pc1",  {48'd0, if_id_pc1}, 64'h9);
      chk("d_addr", {48'd0, imem_addr}, 64'hA);
      nop0 = '0; stall1 = '0;
      cyc();
      chk("d_v1_empty", {63'd0, if_id_valid1}, 64'd0);

      // Branch while waiting: DROP, stale data discarded, odd target.
      branch_taken = 1'b1; branch_address = 16'h0035;
      cyc();
      chk("e_req",  {63'd0, imem_req}, 64'd1);
      chk("e_addr", {48'd0, imem_addr}, 64'hA);
      branch_taken = 1'b0; imem_ready = 1'b1;
      cyc();
      chk("e_v0_drop", {63'd0, if_id_valid0}, 64'd0);
      chk("e_v1_drop", {63'd0, if_id_valid1}, 64'd0);
      chk("e_addr_tgt", {48'd0, imem_addr}, 64'h35);
      push(16'h0036, 16'h0035, 1'b1);
      sb_on = 1'b1;
      cyc();
      sb_on = 1'b0;

      // Second branch in DROP overwrites the saved target.
      imem_ready = 1'b0; branch_taken = 1'b1; branch_address = 16'h0100;
      cyc();
      branch_address = 16'h0200;
      cyc();
      branch_taken = 1'b0; imem_ready = 1'b1;
      cyc();
      chk("e_ovr_addr", {48'd0, imem_addr}, 64'h200);

      // Branch with ready to the top of memory: pair wraps to address 0.
      branch_taken = 1'b1; branch_address = 16'hFFFF;
      cyc();
      chk("w_addr", {48'd0, imem_addr}, 64'hFFFF);
      chk("w_v0",   {63'd0, if_id_valid0}, 64'd0);
      branch_taken = 1'b0;
      push(16'h0000, 16'hFFFF, 1'b1); push(16'h0002, 16'h0001, 1'b1);
      sb_on = 1'b1;
      cyc(); cyc();
      sb_on = 1'b0;
      chk("w_addr_next", {48'd0, imem_addr}, 64'h3);

      // Reset in the middle of BUFFERED.
      stall0 = M_PC_IFID; stall1 = M_PC_IFID;
      cyc();
      chk("f_req_buf", {63'd0, imem_req}, 64'd0);
      reset = 1'b0;
      #1;
      chk("f_req",   {63'd0, imem_req}, 64'd0);
      chk("f_v0",    {63'd0, if_id_valid0}, 64'd0);
      chk("f_v1",    {63'd0, if_id_valid1}, 64'd0);
      chk("f_pc1",   {48'd0, if_id_pc1}, 64'd0);
      chk("f_first", {63'd0, first}, 64'd0);
      chk("f_i1",    {32'd0, if_id_instruction1}, {32'd0, NOP_W});
      chk("f_addr",  {48'd0, imem_addr}, 64'd0);
      stall0 = '0; stall1 = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("f_rel_req", {63'd0, imem_req}, 64'd1);
      push(16'd0, 16'd1, 1'b0);
      sb_on = 1'b1;
      cyc();
      sb_on = 1'b0;
      chk("f_addr_next", {48'd0, imem_addr}, 64'h2);
      chk("sb_drain", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
